// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: CPU load/store handshake plus word-addressed data-memory port.
interface mem_access_unit_if #(
  parameter int ADD_WIDTH  = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  req;
  logic                  is_store;
  logic [1:0]            size;
  logic                  sign_ext;
  logic [ADD_WIDTH-1:0]  addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  busy;
  logic                  done;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  err;
  logic [ADD_WIDTH-1:0]  mem_address;
  logic                  mem_write_enable;
  logic [DATA_WIDTH-1:0] mem_write_data;
  logic [DATA_WIDTH-1:0] mem_read_data;
  modport master (
    output req, is_store, size, sign_ext, addr, wdata, mem_read_data,
    input  busy, done, rdata, err, mem_address, mem_write_enable, mem_write_data
  );
  modport slave (
    input  req, is_store, size, sign_ext, addr, wdata, mem_read_data,
    output busy, done, rdata, err, mem_address, mem_write_enable, mem_write_data
  );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: byte/half/word load-store initiator with read-modify-write sub-word stores; define MISALIGN_CHECK_EN to flag misaligned/illegal accesses with err.
module mem_access_unit #(
  parameter int ADD_WIDTH  = 32,
  parameter int DATA_WIDTH = 32
) (
  input logic              clk,
  input logic              reset_n,
  mem_access_unit_if.slave bus
);
  if (DATA_WIDTH != 32) begin : g_bad_width
    $error("mem_access_unit supports DATA_WIDTH=32 only");
  end
  typedef enum logic [2:0] {IDLE, LOAD, RMW_RD, WRITE, RESP} state_t;
  state_t                state_q, state_d;
  logic [ADD_WIDTH-1:0]  addr_q, addr_d, addr_al;
  logic [15:0]           wdata_q, wdata_d;
  logic [1:0]            size_q, size_d, size_eff;
  logic                  sext_q, sext_d, err_q, err_d, bad;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d, wr_q, wr_d;
  logic [DATA_WIDTH-1:0] load_val, lane_mask, lane_ins, merged;
  logic [7:0]            ld_b;
  logic [15:0]           ld_h;
`ifdef MISALIGN_CHECK_EN
  assign size_eff = bus.size;
  assign addr_al  = bus.addr;
  assign bad      = (bus.size == 2'b11) | ((bus.size == 2'b01) & bus.addr[0]) |
                    ((bus.size == 2'b10) & (|bus.addr[1:0]));
`else
  // Without checking, illegal size behaves as word and low address bits are forced to alignment.
  assign size_eff = (bus.size == 2'b11) ? 2'b10 : bus.size;
  assign addr_al  = {bus.addr[ADD_WIDTH-1:2], bus.addr[1] & ~size_eff[1], bus.addr[0] & (size_eff == 2'b00)};
  assign bad      = 1'b0;
`endif
  assign ld_b      = bus.mem_read_data[{addr_q[1:0], 3'b000} +: 8];
  assign ld_h      = bus.mem_read_data[{addr_q[1], 4'b0000} +: 16];
  assign load_val  = (size_q == 2'b00) ? {{24{sext_q & ld_b[7]}}, ld_b} :
                     (size_q == 2'b01) ? {{16{sext_q & ld_h[15]}}, ld_h} : bus.mem_read_data;
  assign lane_mask = (size_q == 2'b00) ? 32'h0000_00FF << {addr_q[1:0], 3'b000} :
                                         32'h0000_FFFF << {addr_q[1], 4'b0000};
  assign lane_ins  = (size_q == 2'b00) ? {4{wdata_q[7:0]}} : {2{wdata_q}};
  assign merged    = (bus.mem_read_data & ~lane_mask) | (lane_ins & lane_mask);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= '0;
      sext_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      wr_q    <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      sext_q  <= sext_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      wr_q    <= wr_d;
    end
  end
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    size_d  = size_q;
    sext_d  = sext_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    wr_d    = wr_q;
    case (state_q)
      IDLE: if (bus.req) begin
        addr_d  = addr_al;
        wdata_d = bus.wdata[15:0];
        size_d  = size_eff;
        sext_d  = bus.sign_ext;
        err_d   = bad;
        wr_d    = bus.wdata;
        state_d = bad ? RESP : !bus.is_store ? LOAD : (size_eff == 2'b10) ? WRITE : RMW_RD;
      end
      LOAD: begin
        rdata_d = load_val;
        state_d = RESP;
      end
      RMW_RD: begin
        wr_d    = merged;
        state_d = WRITE;
      end
      WRITE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  assign bus.busy             = state_q != IDLE;
  assign bus.done             = state_q == RESP;
  assign bus.err              = err_q & (state_q == RESP);
  assign bus.rdata            = rdata_q;
  assign bus.mem_address      = {2'b00, addr_q[ADD_WIDTH-1:2]};
  assign bus.mem_write_enable = state_q == WRITE;
  assign bus.mem_write_data   = wr_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: scoreboard bench with directed load/store vectors against a small word memory.
module tb_mem_access_unit;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int checks = 0, fails = 0, cyc = 0, done_cnt = 0, last_done = 0, prev_done = 0;
  logic [32:0] resp_q[$];
  logic [63:0] wr_q[$];
  logic [31:0] mem [0:15];
  logic [31:0] w2;
  int base;
  mem_access_unit_if #(.ADD_WIDTH(32), .DATA_WIDTH(32)) bus ();
  mem_access_unit #(.ADD_WIDTH(32), .DATA_WIDTH(32)) dut (.clk(clk), .reset_n(reset_n), .bus(bus.slave));
  always #5 clk = ~clk;
  assign bus.mem_read_data = mem[bus.mem_address[3:0]];
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.mem_write_enable) mem[bus.mem_address[3:0]] <= bus.mem_write_data;
  end
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask
  initial forever begin
    logic [32:0] er;
    logic [63:0] ew;
    @(negedge clk);
    if (bus.done === 1'b1) begin
      done_cnt++;
      prev_done = last_done;
      last_done = cyc;
      er = 'x;
      if (resp_q.size() != 0) er = resp_q.pop_front();
      chk("response busy/err/rdata", {31'b0, bus.busy, bus.err, bus.rdata}, {31'b0, 1'b1, er});
    end
    if (bus.mem_write_enable === 1'b1) begin
      ew = 'x;
      if (wr_q.size() != 0) ew = wr_q.pop_front();
      chk("mem write addr/data", {bus.mem_address, bus.mem_write_data}, ew);
    end
  end
  task automatic access(input logic st, input logic [1:0] sz, input logic sx, input logic [31:0] a,
                        input logic [31:0] wd, input logic e_err, input logic [31:0] e_rd, input int e_lat);
    int n;
    bus.req = 1'b1; bus.is_store = st; bus.size = sz; bus.sign_ext = sx; bus.addr = a; bus.wdata = wd;
    resp_q.push_back({e_err, e_rd});
    @(posedge clk); #1;
    bus.req = 1'b0;
    n = 0;
    while (bus.done !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("done latency", 64'(n), 64'(e_lat));
    @(posedge clk); #1;
  endtask
  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    mem[0] = 32'hCAFE_F00D;
    mem[1] = 32'h1122_3344;
    bus.req = 1'b0; bus.is_store = 1'b0; bus.size = 2'b00; bus.sign_ext = 1'b0; bus.addr = '0; bus.wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", 64'(bus.busy), 64'd0);
    chk("reset done", 64'(bus.done), 64'd0);
    chk("reset err", 64'(bus.err), 64'd0);
    chk("reset rdata", 64'(bus.rdata), 64'd0);
    chk("reset mem_write_enable", 64'(bus.mem_write_enable), 64'd0);
    chk("reset mem_address", 64'(bus.mem_address), 64'd0);
    chk("reset mem_write_data", 64'(bus.mem_write_data), 64'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    wr_q.push_back({32'd2, 32'hDEAD_BEEF});
    access(1, 2'b10, 0, 32'h08, 32'hDEAD_BEEF, 0, 32'h0, 1);
    access(0, 2'b10, 0, 32'h08, 32'h0, 0, 32'hDEAD_BEEF, 1);
    access(0, 2'b00, 1, 32'h09, 32'h0, 0, 32'hFFFF_FFBE, 1);
    access(0, 2'b00, 0, 32'h09, 32'h0, 0, 32'h0000_00BE, 1);
    access(0, 2'b00, 1, 32'h0B, 32'h0, 0, 32'hFFFF_FFDE, 1);
    wr_q.push_back({32'd2, 32'h1234_BEEF});
    access(1, 2'b01, 0, 32'h0A, 32'h0000_1234, 0, 32'hFFFF_FFDE, 2);
    access(0, 2'b01, 0, 32'h0A, 32'h0, 0, 32'h0000_1234, 1);
    access(0, 2'b01, 1, 32'h08, 32'h0, 0, 32'hFFFF_BEEF, 1);
    wr_q.push_back({32'd2, 32'hAB34_BEEF});
    access(1, 2'b00, 0, 32'h0B, 32'hFFFF_FFAB, 0, 32'hFFFF_BEEF, 2);
    access(0, 2'b00, 0, 32'h0B, 32'h0, 0, 32'h0000_00AB, 1);
`ifdef MISALIGN_CHECK_EN
    access(0, 2'b10, 0, 32'h06, 32'h0, 1, 32'h0000_00AB, 0);
    access(1, 2'b01, 0, 32'h09, 32'h0000_5566, 1, 32'h0000_00AB, 0);
    access(0, 2'b11, 0, 32'h08, 32'h0, 1, 32'h0000_00AB, 0);
    w2 = 32'hAB34_BEEF;
`else
    access(0, 2'b10, 0, 32'h06, 32'h0, 0, 32'h1122_3344, 1);
    wr_q.push_back({32'd2, 32'hAB34_5566});
    access(1, 2'b01, 0, 32'h09, 32'h0000_5566, 0, 32'h1122_3344, 2);
    access(0, 2'b11, 0, 32'h08, 32'h0, 0, 32'hAB34_5566, 1);
    w2 = 32'hAB34_5566;
`endif
    bus.req = 1'b1; bus.is_store = 1'b1; bus.size = 2'b00; bus.sign_ext = 1'b0; bus.addr = 32'h08; bus.wdata = 32'h77;
    @(posedge clk); #1;
    bus.req = 1'b0;
    chk("busy in RMW_RD", 64'(bus.busy), 64'd1);
    reset_n = 1'b0;
    #1;
    chk("abort busy", 64'(bus.busy), 64'd0);
    chk("abort done", 64'(bus.done), 64'd0);
    chk("abort mem_write_enable", 64'(bus.mem_write_enable), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("idle after abort", 64'(bus.busy), 64'd0);
    chk("rdata after abort", 64'(bus.rdata), 64'd0);
    chk("memory intact after abort", 64'(mem[2]), 64'(w2));
    access(0, 2'b10, 0, 32'h08, 32'h0, 0, w2, 1);
    base = done_cnt;
    resp_q.push_back({1'b0, 32'hCAFE_F00D});
    resp_q.push_back({1'b0, 32'hCAFE_F00D});
    bus.req = 1'b1; bus.is_store = 1'b0; bus.size = 2'b10; bus.sign_ext = 1'b0; bus.addr = 32'h00; bus.wdata = 32'h0;
    repeat (4) @(posedge clk);
    #1;
    bus.req = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("accesses from held req", 64'(done_cnt - base), 64'd2);
    chk("back-to-back done spacing", 64'(last_done - prev_done), 64'd3);
    chk("response queue drained", 64'(resp_q.size()), 64'd0);
    chk("write queue drained", 64'(wr_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
